if_pc_stage: RTL and testbench
==============================

Name: if_pc_stage

Overview:
- Fetch-stage sequential core: holds the current PC and drives the instruction-memory request.
- Feeds `cur_pc` back to the combinational next-PC logic and captures `next_pc` when an instruction is accepted.
- Holds the IF/ID pipeline register, with a one-entry skid buffer, consumed by decode.
- Handles decode stalls, control-transfer flushes and variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, value of id_instr when id_valid=0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- next_pc  input  32  next fetch address from the next-PC logic (combinational function of cur_pc).
- cur_pc  output  32  current fetch address; drives imem address and the next-PC logic.
- imem_req  output  1  fetch request for address cur_pc.
- imem_ack  input  1  imem_rdata valid for cur_pc this cycle; no outstanding transactions.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  decode cannot accept a new instruction (hazard unit).
- flush  input  1  control transfer taken; squash fetched/buffered instructions and redirect.
- id_valid  output  1  IF/ID holds a live instruction.
- id_instr  output  32  IF/ID instruction.
- id_pc  output  32  IF/ID instruction address.
- id_pc_plus4  output  32  id_pc+4, mod 2^32.
- fetch_busy  output  1  high in BUF state.

Behaviour:
- States:
  - REQ: requesting. `imem_req = ~reset`.
  - BUF: skid buffer full. `imem_req = 0`.
- Reset (synchronous, highest priority):
  - State ← REQ, cur_pc ← RESET_PC, skid empty.
  - id_valid ← 0, id_instr ← NOP_WORD, id_pc ← 0, id_pc_plus4 ← 0.
  - imem_req is 0 while reset is asserted.
- Accept condition: `accept = ~stall | ~id_valid`. A bubble never blocks.
- REQ with imem_ack=1, flush=0, accept=1:
  - IF/ID ← {imem_rdata, cur_pc, cur_pc+4}, id_valid ← 1.
  - cur_pc ← next_pc. Stay in REQ.
  - Latency: id_* valid one cycle after the ack.
- REQ with imem_ack=1, flush=0, accept=0:
  - Skid ← {imem_rdata, cur_pc}, cur_pc ← next_pc, go to BUF.
  - IF/ID unchanged.
- REQ with imem_ack=0, flush=0:
  - cur_pc holds.
  - If accept=1 and stall=0, id_valid ← 0 (bubble); otherwise IF/ID holds.
- BUF with stall=1, flush=0: everything holds and no request is issued.
- BUF with stall=0, flush=0:
  - IF/ID ← skid (id_pc_plus4 = skid pc+4), skid empty, go to REQ.
  - cur_pc does not change; it was already advanced on entry to BUF.
- flush=1 in any state, reset=0 (priority over stall and imem_ack):
  - id_valid ← 0, id_instr ← NOP_WORD, skid cleared.
  - cur_pc ← next_pc (redirect target), go to REQ.
  - An imem_ack in the same cycle is discarded.
- Simultaneous flush and stall: flush wins.
- Data handling:
  - next_pc is used verbatim, including bits [1:0].
  - +4 wraps: FFFF_FFFC → 0000_0000.
- Invariant: the pair (id_valid, skid) never drops or duplicates an instruction absent flush.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - perf_fetched (32): increments on every IF/ID load from imem or skid.
  - perf_stall_cyc (32): increments each cycle with stall=1 and id_valid=1.
  - Both clear on reset and saturate at FFFF_FFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - State enum {REQ, BUF}.
  - RESET_PC default and NOP_WORD constants.
  - Fetch-bundle struct {instr[31:0], pc[31:0]}.
- Sub-module if_skid_buf: one-entry buffer with load/drain/clear inputs and full output; it holds the fetch bundle.

Test Plan:
- Reset, then imem_ack=1 every cycle, next_pc=cur_pc+4 → imem_req low during reset; id_pc sequence 3000, 3004, 3008; id_pc_plus4 = id_pc+4; id_valid high from the 2nd cycle after reset release.
- Ack for 3004 while stall=1 and id_valid=1 → fetch_busy=1, cur_pc=3008, imem_req=0. Release stall → id_pc=3004 next cycle, then REQ for 3008, with no loss or duplication.
- flush=1 with next_pc=0000_4000 and imem_ack=1 in the same cycle → id_valid=0, id_instr=0, ack data discarded, cur_pc=4000; the next id_pc is 4000.
- flush and stall both high while in BUF → skid cleared, state REQ, cur_pc=next_pc.
- cur_pc=FFFF_FFFC ack → id_pc_plus4=0000_0000. imem_ack held low for 3 cycles → cur_pc holds, id_valid=0 after the first idle cycle.
- With IF_PERF_CNT_EN, 10 fetches and 4 stall cycles → perf_fetched=10, perf_stall_cyc=4. Reset mid-run → both counters 0.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the instruction-fetch stage:
//                FSM state encoding, reset/NOP constants, the fetch bundle
//                carried by the skid buffer, and a PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // REQ: a fetch request is outstanding for cur_pc.
    // BUF: skid buffer full; no request is issued.
    typedef enum logic [0:0] {
        ST_REQ = 1'b0,
        ST_BUF = 1'b1
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] c_NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_bundle_t;

    // Sequential-address increment; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_skid_buf
//  Description : One-entry skid buffer holding a fetch bundle that arrived
//                while decode could not accept it.
//  Ports       : clk, reset  - clock / synchronous active-high reset
//                load        - capture load_data, mark full
//                drain       - entry consumed, mark empty
//                clear       - squash entry (wins over load and drain)
//                load_data   - bundle to capture
//                data, full  - stored bundle and occupancy flag
//  Revision    : 1.0 - initial release
// ============================================================================
module if_skid_buf
    import if_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          drain,
    input  logic          clear,
    input  fetch_bundle_t load_data,
    output fetch_bundle_t data,
    output logic          full
);

    fetch_bundle_t r_data;
    logic          r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (clear) begin
            r_full <= 1'b0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= load_data;
        end else if (drain) begin
            r_full <= 1'b0;
        end
    end

    assign data = r_data;
    assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/if_pc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_pc_stage
//  Description : Fetch-stage sequential core. Holds the fetch PC, issues
//                instruction-memory requests, and owns the IF/ID pipeline
//                register backed by a one-entry skid buffer so an ack that
//                lands during a decode stall is never lost.
//  Ports       : clk, reset            - clock / sync active-high reset
//                next_pc / cur_pc      - next-PC loop (cur_pc feeds imem too)
//                imem_req/ack/rdata    - variable-latency instruction memory
//                stall, flush          - decode hazard stall / redirect
//                id_valid, id_instr,
//                id_pc, id_pc_plus4    - IF/ID register to decode
//                fetch_busy            - skid buffer occupied (BUF state)
//                perf_fetched,
//                perf_stall_cyc        - saturating counters, only when
//                                        IF_PERF_CNT_EN is defined
//  Options     : `define IF_PERF_CNT_EN to add the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_pc_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = c_NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    output logic [31:0] cur_pc,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cyc
`endif
);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;

    logic [31:0]   r_cur_pc;
    logic          r_id_valid;
    logic [31:0]   r_id_instr;
    logic [31:0]   r_id_pc;
    logic [31:0]   r_id_pc_plus4;

    logic          w_accept;
    logic          w_load_imem;   // IF/ID <- imem data
    logic          w_load_skid;   // IF/ID <- skid entry
    logic          w_skid_load;
    logic          w_skid_clear;
    logic          w_pc_advance;
    logic          w_bubble;
    logic          w_squash;

    fetch_bundle_t w_skid_in;
    fetch_bundle_t w_skid_data;
    logic          w_skid_full;

    // An empty IF/ID slot can always take a new instruction, even under stall.
    assign w_accept = ~stall | ~r_id_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, datapath strobes and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_imem  = 1'b0;
        w_load_skid  = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_pc_advance = 1'b0;
        w_bubble     = 1'b0;
        w_squash     = 1'b0;
        imem_req     = 1'b0;
        fetch_busy   = 1'b0;

        case (r_state)
            ST_REQ:  imem_req   = ~reset;
            ST_BUF:  fetch_busy = 1'b1;
            default: ;
        endcase

        if (flush) begin
            // Redirect: anything fetched or buffered is on the wrong path,
            // including an ack arriving this very cycle.
            w_squash     = 1'b1;
            w_skid_clear = 1'b1;
            w_pc_advance = 1'b1;
            w_state_next = ST_REQ;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem_ack) begin
                        w_pc_advance = 1'b1;
                        if (w_accept) begin
                            w_load_imem = 1'b1;
                        end else begin
                            w_skid_load  = 1'b1;
                            w_state_next = ST_BUF;
                        end
                    end else if (~stall) begin
                        // Decode consumed IF/ID and nothing replaces it.
                        w_bubble = 1'b1;
                    end
                end
                ST_BUF: begin
                    // cur_pc was already advanced when the skid filled.
                    if (~stall) begin
                        w_load_skid  = w_skid_full;
                        w_state_next = ST_REQ;
                    end
                end
                default: w_state_next = ST_REQ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_pc      <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_WORD;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd0;
        end else begin
            if (w_pc_advance) begin
                r_cur_pc <= next_pc;
            end

            if (w_squash || w_bubble) begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_WORD;
            end else if (w_load_imem) begin
                r_id_valid    <= 1'b1;
                r_id_instr    <= imem_rdata;
                r_id_pc       <= r_cur_pc;
                r_id_pc_plus4 <= pc_plus4(r_cur_pc);
            end else if (w_load_skid) begin
                r_id_valid    <= 1'b1;
                r_id_instr    <= w_skid_data.instr;
                r_id_pc       <= w_skid_data.pc;
                r_id_pc_plus4 <= pc_plus4(w_skid_data.pc);
            end
        end
    end

    assign w_skid_in.instr = imem_rdata;
    assign w_skid_in.pc    = r_cur_pc;

    if_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (w_skid_load),
        .drain     (w_load_skid),
        .clear     (w_skid_clear),
        .load_data (w_skid_in),
        .data      (w_skid_data),
        .full      (w_skid_full)
    );

    assign cur_pc      = r_cur_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall_cyc;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched   <= 32'd0;
            r_perf_stall_cyc <= 32'd0;
        end else begin
            if ((w_load_imem || w_load_skid) && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (stall && r_id_valid && (r_perf_stall_cyc != 32'hFFFF_FFFF)) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_pc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_pc_stage
//  Description : Self-checking bench for if_pc_stage. A queue of fetched but
//                not yet retired instructions (IF/ID front, skid behind) is
//                the reference model; directed scenarios plus a randomized
//                run are compared against it.
//  Options     : IF_PERF_CNT_EN enables the performance-counter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_pc_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic [31:0] cur_pc;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_busy;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
`endif

    int total = 0;
    int bad   = 0;

    if_pc_stage #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .cur_pc      (cur_pc),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .fetch_busy  (fetch_busy)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model: in-order queue of fetched instructions that decode
    // has not yet taken. Front = IF/ID contents, second entry = skid.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    longint      m_fetched;
    longint      m_stallc;

    task automatic model_reset();
        q.delete();
        m_pc      = RESET_PC;
        m_fetched = 0;
        m_stallc  = 0;
    endtask

    // One clock cycle with the given inputs; updates the model at the edge.
    task automatic step(input logic s, input logic f, input logic a, input logic [31:0] np);
        logic [31:0] rd;
        int          sz;
        rd = $urandom;
        @(negedge clk);
        stall      = s;
        flush      = f;
        imem_ack   = a;
        imem_rdata = rd;
        next_pc    = np;
        @(posedge clk);
        sz = q.size();
        if (s && sz > 0) m_stallc++;
        if (f) begin
            q.delete();
            m_pc = np;
        end else begin
            if (!s && sz > 0) begin
                void'(q.pop_front());
                if (q.size() > 0) m_fetched++;
            end
            // Only requesting while fewer than two entries are held.
            if (sz < 2 && a) begin
                q.push_back('{instr: rd, pc: m_pc});
                m_pc = np;
                if (q.size() == 1) m_fetched++;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        next_pc    = 32'h0000_1234;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total += 7;
        if (imem_req !== 1'b0)     begin bad++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        if (cur_pc !== RESET_PC)   begin bad++; $display("FAIL rst_cur_pc: got %h want %h", cur_pc, RESET_PC); end
        if (id_valid !== 1'b0)     begin bad++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
        if (id_instr !== NOP_WORD) begin bad++; $display("FAIL rst_id_instr: got %h want %h", id_instr, NOP_WORD); end
        if (id_pc !== 32'd0)       begin bad++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
        if (id_pc_plus4 !== 32'd0) begin bad++; $display("FAIL rst_id_pc_plus4: got %h want 0", id_pc_plus4); end
        if (fetch_busy !== 1'b0)   begin bad++; $display("FAIL rst_fetch_busy: got %b want 0", fetch_busy); end
`ifdef IF_PERF_CNT_EN
        total += 2;
        if (perf_fetched !== 32'd0)   begin bad++; $display("FAIL rst_perf_fetched: got %0d want 0", perf_fetched); end
        if (perf_stall_cyc !== 32'd0) begin bad++; $display("FAIL rst_perf_stall: got %0d want 0", perf_stall_cyc); end
`endif
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_imem_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
            exp_pc = RESET_PC + 32'(4 * i);
            total += 4;
            if (id_valid !== 1'b1)              begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", i, id_valid); end
            if (id_pc !== exp_pc)               begin bad++; $display("FAIL seq_id_pc[%0d]: got %h want %h", i, id_pc, exp_pc); end
            if (id_pc_plus4 !== exp_pc + 32'd4) begin bad++; $display("FAIL seq_plus4[%0d]: got %h want %h", i, id_pc_plus4, exp_pc + 32'd4); end
            if (id_instr !== q[0].instr)        begin bad++; $display("FAIL seq_instr[%0d]: got %h want %h", i, id_instr, q[0].instr); end
        end
    endtask

    task automatic test_stall_skid();
        logic [31:0] skid_instr;
        apply_reset();
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);       // IF/ID = 3000
        step(1'b1, 1'b0, 1'b1, m_pc + 32'd4);       // ack 3004 under stall -> skid
        skid_instr = q[1].instr;
        total += 4;
        if (fetch_busy !== 1'b1)      begin bad++; $display("FAIL skid_busy: got %b want 1", fetch_busy); end
        if (cur_pc !== 32'h0000_3008) begin bad++; $display("FAIL skid_cur_pc: got %h want 00003008", cur_pc); end
        if (imem_req !== 1'b0)        begin bad++; $display("FAIL skid_req: got %b want 0", imem_req); end
        if (id_pc !== 32'h0000_3000)  begin bad++; $display("FAIL skid_hold_pc: got %h want 00003000", id_pc); end
        step(1'b1, 1'b0, 1'b0, m_pc + 32'd4);       // still stalled: hold
        total += 2;
        if (fetch_busy !== 1'b1)     begin bad++; $display("FAIL skid_hold_busy: got %b want 1", fetch_busy); end
        if (id_pc !== 32'h0000_3000) begin bad++; $display("FAIL skid_hold2_pc: got %h want 00003000", id_pc); end
        step(1'b0, 1'b0, 1'b0, m_pc + 32'd4);       // release: skid -> IF/ID
        total += 6;
        if (id_pc !== 32'h0000_3004)       begin bad++; $display("FAIL drain_pc: got %h want 00003004", id_pc); end
        if (id_pc_plus4 !== 32'h0000_3008) begin bad++; $display("FAIL drain_plus4: got %h want 00003008", id_pc_plus4); end
        if (id_instr !== skid_instr)       begin bad++; $display("FAIL drain_instr: got %h want %h", id_instr, skid_instr); end
        if (fetch_busy !== 1'b0)           begin bad++; $display("FAIL drain_busy: got %b want 0", fetch_busy); end
        if (imem_req !== 1'b1)             begin bad++; $display("FAIL drain_req: got %b want 1", imem_req); end
        if (cur_pc !== 32'h0000_3008)      begin bad++; $display("FAIL drain_cur_pc: got %h want 00003008", cur_pc); end
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        total += 2;
        if (id_pc !== 32'h0000_3008) begin bad++; $display("FAIL after_drain_pc: got %h want 00003008", id_pc); end
        if (id_valid !== 1'b1)       begin bad++; $display("FAIL after_drain_valid: got %b want 1", id_valid); end
    endtask

    task automatic test_flush_ack();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        step(1'b0, 1'b1, 1'b1, 32'h0000_4000);
        total += 3;
        if (id_valid !== 1'b0)        begin bad++; $display("FAIL flush_valid: got %b want 0", id_valid); end
        if (id_instr !== NOP_WORD)    begin bad++; $display("FAIL flush_instr: got %h want %h", id_instr, NOP_WORD); end
        if (cur_pc !== 32'h0000_4000) begin bad++; $display("FAIL flush_cur_pc: got %h want 00004000", cur_pc); end
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        total += 2;
        if (id_pc !== 32'h0000_4000) begin bad++; $display("FAIL flush_next_pc: got %h want 00004000", id_pc); end
        if (id_valid !== 1'b1)       begin bad++; $display("FAIL flush_next_valid: got %b want 1", id_valid); end
    endtask

    task automatic test_flush_stall_buf();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        step(1'b1, 1'b0, 1'b1, m_pc + 32'd4);       // enter BUF
        step(1'b1, 1'b1, 1'b0, 32'h0000_5000);      // flush beats stall
        total += 4;
        if (fetch_busy !== 1'b0)      begin bad++; $display("FAIL fsb_busy: got %b want 0", fetch_busy); end
        if (imem_req !== 1'b1)        begin bad++; $display("FAIL fsb_req: got %b want 1", imem_req); end
        if (cur_pc !== 32'h0000_5000) begin bad++; $display("FAIL fsb_cur_pc: got %h want 00005000", cur_pc); end
        if (id_valid !== 1'b0)        begin bad++; $display("FAIL fsb_valid: got %b want 0", id_valid); end
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        total += 1;
        if (id_pc !== 32'h0000_5000) begin bad++; $display("FAIL fsb_next_pc: got %h want 00005000", id_pc); end
    endtask

    task automatic test_wrap_idle();
        apply_reset();
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        total += 3;
        if (id_pc !== 32'hFFFF_FFFC)  begin bad++; $display("FAIL wrap_pc: got %h want fffffffc", id_pc); end
        if (id_pc_plus4 !== 32'd0)    begin bad++; $display("FAIL wrap_plus4: got %h want 00000000", id_pc_plus4); end
        if (cur_pc !== 32'h0000_0000) begin bad++; $display("FAIL wrap_cur_pc: got %h want 00000000", cur_pc); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0000_0abc);
            total += 3;
            if (cur_pc !== 32'h0000_0000) begin bad++; $display("FAIL idle_cur_pc[%0d]: got %h want 00000000", i, cur_pc); end
            if (id_valid !== 1'b0)        begin bad++; $display("FAIL idle_valid[%0d]: got %b want 0", i, id_valid); end
            if (id_instr !== NOP_WORD)    begin bad++; $display("FAIL idle_instr[%0d]: got %h want %h", i, id_instr, NOP_WORD); end
        end
    endtask

    task automatic test_random();
        logic        s, f, a;
        logic [31:0] np;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            s  = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 99) < 8);
            a  = ($urandom_range(0, 9) < 6) && (q.size() < 2);
            np = ($urandom_range(0, 3) == 0) ? 32'($urandom) : m_pc + 32'd4;
            step(s, f, a, np);
            total += 4;
            if (id_valid !== (q.size() > 0))   begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, id_valid, q.size() > 0); end
            if (cur_pc !== m_pc)               begin bad++; $display("FAIL rnd_cur_pc[%0d]: got %h want %h", i, cur_pc, m_pc); end
            if (imem_req !== (q.size() < 2))   begin bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, q.size() < 2); end
            if (fetch_busy !== (q.size() == 2)) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, fetch_busy, q.size() == 2); end
            if (q.size() > 0) begin
                total += 3;
                if (id_pc !== q[0].pc)                begin bad++; $display("FAIL rnd_id_pc[%0d]: got %h want %h", i, id_pc, q[0].pc); end
                if (id_instr !== q[0].instr)          begin bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, id_instr, q[0].instr); end
                if (id_pc_plus4 !== q[0].pc + 32'd4)  begin bad++; $display("FAIL rnd_plus4[%0d]: got %h want %h", i, id_pc_plus4, q[0].pc + 32'd4); end
            end else begin
                total += 1;
                if (id_instr !== NOP_WORD) begin bad++; $display("FAIL rnd_nop[%0d]: got %h want %h", i, id_instr, NOP_WORD); end
            end
`ifdef IF_PERF_CNT_EN
            total += 2;
            if (perf_fetched !== 32'(m_fetched))  begin bad++; $display("FAIL rnd_perf_f[%0d]: got %0d want %0d", i, perf_fetched, m_fetched); end
            if (perf_stall_cyc !== 32'(m_stallc)) begin bad++; $display("FAIL rnd_perf_s[%0d]: got %0d want %0d", i, perf_stall_cyc, m_stallc); end
`endif
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        repeat (4) step(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
        repeat (9) step(1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        total += 2;
        if (perf_fetched !== 32'd10)  begin bad++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched); end
        if (perf_stall_cyc !== 32'd4) begin bad++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cyc); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total += 2;
        if (perf_fetched !== 32'd0)   begin bad++; $display("FAIL perf_rst_f: got %0d want 0", perf_fetched); end
        if (perf_stall_cyc !== 32'd0) begin bad++; $display("FAIL perf_rst_s: got %0d want 0", perf_stall_cyc); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        next_pc    = 32'd0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall_skid();
        test_flush_ack();
        test_flush_stall_buf();
        test_wrap_idle();
        test_random();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
